bf_dly_stage: RTL and testbench

- Parametrised radix-2 delay-buffer butterfly stage for the multi-lane FFT pipeline.
- Generalises the fixed 16-lane, 10-bit stage to configurable lane count, sample width and delay depth.
- Adds optional per-beat divide-by-2 scaling, a synchronous block-realign clear, output position index and an end-of-block pulse.
- Each block is 2*DEPTH valid beats. The first half is buffered; each second-half beat is butterflied against the buffered beat of the same position.

---
 rtl/bf_dly_stage.sv | 122 ++++++++++++
 tb/tb_bf_dly_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bf_dly_stage.sv
// Radix-2 delay-buffer butterfly stage: buffers the first half of each block and
// butterflies every second-half beat against the stored beat of the same position.
module bf_dly_stage #(
  parameter int LANES = 16,
  parameter int IW    = 10,
  parameter int OW    = IW + 1,
  parameter int DEPTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      din_valid,
  input  logic [LANES*IW-1:0]                       din_re,
  input  logic [LANES*IW-1:0]                       din_im,
  input  logic                                      scale_en,
  input  logic                                      sync_clr,
  output logic                                      dout_valid,
  output logic [LANES*OW-1:0]                       dout_sum_re,
  output logic [LANES*OW-1:0]                       dout_sum_im,
  output logic [LANES*OW-1:0]                       dout_dif_re,
  output logic [LANES*OW-1:0]                       dout_dif_im,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] dout_idx,
  output logic                                      blk_done
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW   = $clog2(2 * DEPTH);
  localparam int NBUF = 1 << IDXW;
  localparam logic [PW-1:0] KMASK = PW'(DEPTH - 1);

  function automatic logic signed [OW-1:0] scale_half(input logic signed [OW-1:0] v,
                                                      input logic en);
    return en ? (v >>> 1) : v;
  endfunction

  logic [PW-1:0]       pos_q, pos_d;
  logic [IDXW-1:0]     k;
  logic                second_half, accept, res_vld;
  logic                vld_q, vld_d, done_q, done_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [LANES*IW-1:0] buf_re_q [NBUF];
  logic [LANES*IW-1:0] buf_im_q [NBUF];
  logic [LANES*OW-1:0] sum_re_w, sum_im_w, dif_re_w, dif_im_w;
  logic [LANES*OW-1:0] sum_re_q, sum_im_q, dif_re_q, dif_im_q;
  logic [LANES*OW-1:0] sum_re_d, sum_im_d, dif_re_d, dif_im_d;

  // DEPTH is a power of two, so the top pos bit marks the second half and the rest is k.
  assign k           = IDXW'(pos_q & KMASK);
  assign second_half = pos_q[PW-1];
  assign accept      = din_valid & ~sync_clr;
  assign res_vld     = accept & second_half;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [IW-1:0] a_re, a_im, b_re, b_im;
    logic signed [OW-1:0] ae_re, ae_im, be_re, be_im;
    assign a_re  = buf_re_q[k][g*IW +: IW];
    assign a_im  = buf_im_q[k][g*IW +: IW];
    assign b_re  = din_re[g*IW +: IW];
    assign b_im  = din_im[g*IW +: IW];
    assign ae_re = {{(OW-IW){a_re[IW-1]}}, a_re};
    assign ae_im = {{(OW-IW){a_im[IW-1]}}, a_im};
    assign be_re = {{(OW-IW){b_re[IW-1]}}, b_re};
    assign be_im = {{(OW-IW){b_im[IW-1]}}, b_im};
    assign sum_re_w[g*OW +: OW] = scale_half(ae_re + be_re, scale_en);
    assign sum_im_w[g*OW +: OW] = scale_half(ae_im + be_im, scale_en);
    assign dif_re_w[g*OW +: OW] = scale_half(ae_re - be_re, scale_en);
    assign dif_im_w[g*OW +: OW] = scale_half(ae_im - be_im, scale_en);
  end

  always_comb begin
    pos_d = pos_q;
    if (sync_clr)
      pos_d = '0;
    else if (din_valid)
      pos_d = pos_q + 1'b1;
    vld_d    = res_vld;
    done_d   = res_vld && (k == IDXW'(DEPTH - 1));
    idx_d    = res_vld ? k : idx_q;
    sum_re_d = res_vld ? sum_re_w : sum_re_q;
    sum_im_d = res_vld ? sum_im_w : sum_im_q;
    dif_re_d = res_vld ? dif_re_w : dif_re_q;
    dif_im_d = res_vld ? dif_im_w : dif_im_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pos_q    <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      sum_re_q <= '0;
      sum_im_q <= '0;
      dif_re_q <= '0;
      dif_im_q <= '0;
    end else begin
      pos_q    <= pos_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      sum_re_q <= sum_re_d;
      sum_im_q <= sum_im_d;
      dif_re_q <= dif_re_d;
      dif_im_q <= dif_im_d;
    end
  end

  // Buffer is never read before being written in the same block, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rstn && accept && !second_half) begin
      buf_re_q[k] <= din_re;
      buf_im_q[k] <= din_im;
    end
  end

  assign dout_valid  = vld_q;
  assign blk_done    = done_q;
  assign dout_idx    = idx_q;
  assign dout_sum_re = sum_re_q;
  assign dout_sum_im = sum_im_q;
  assign dout_dif_re = dif_re_q;
  assign dout_dif_im = dif_im_q;

endmodule

// File: tb/tb_bf_dly_stage.sv
// Bench for bf_dly_stage: two configurations driven with directed and random beats,
// checked every cycle against a block-level reference model.
module tb_bf_dly_stage;

  localparam int L0 = 16, I0 = 10, O0 = 11, D0 = 8;
  localparam int L1 = 4,  I1 = 16, O1 = 17, D1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic v0, sc0, clr0, ov0, done0;
  logic [L0*I0-1:0] re0, im0;
  logic [L0*O0-1:0] sre0, sim0, dre0, dim0;
  logic [2:0] idx0;
  logic v1, sc1, clr1, ov1, done1;
  logic [L1*I1-1:0] re1, im1;
  logic [L1*O1-1:0] sre1, sim1, dre1, dim1;
  logic [0:0] idx1;

  bf_dly_stage #(.LANES(L0), .IW(I0), .OW(O0), .DEPTH(D0)) dut0 (
    .clk(clk), .rstn(rstn), .din_valid(v0), .din_re(re0), .din_im(im0),
    .scale_en(sc0), .sync_clr(clr0), .dout_valid(ov0),
    .dout_sum_re(sre0), .dout_sum_im(sim0), .dout_dif_re(dre0), .dout_dif_im(dim0),
    .dout_idx(idx0), .blk_done(done0));

  bf_dly_stage #(.LANES(L1), .IW(I1), .OW(O1), .DEPTH(D1)) dut1 (
    .clk(clk), .rstn(rstn), .din_valid(v1), .din_re(re1), .din_im(im1),
    .scale_en(sc1), .sync_clr(clr1), .dout_valid(ov1),
    .dout_sum_re(sre1), .dout_sum_im(sim1), .dout_dif_re(dre1), .dout_dif_im(dim1),
    .dout_idx(idx1), .blk_done(done1));

  int checks = 0, errors = 0;
  int in_re[16], in_im[16];
  bit in_v, in_sc, in_clr;

  // Reference model: beat number within the block and the stored first half.
  int mpos[2];
  int mb_re[2][8][16], mb_im[2][8][16];
  int e_sre[2][16], e_sim[2][16], e_dre[2][16], e_dim[2][16];
  int e_idx[2];
  bit e_vld[2], e_done[2];

  function automatic int fl2(int x);
    return (x >= 0) ? x / 2 : -((1 - x) / 2);
  endfunction

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(int u);
    int nl, nd, k, s_re, s_im, d_re, d_im;
    nl = (u == 0) ? L0 : L1;
    nd = (u == 0) ? D0 : D1;
    if (!rstn) begin
      for (int w = 0; w < 2; w++) begin
        mpos[w] = 0; e_vld[w] = 0; e_done[w] = 0; e_idx[w] = 0;
        for (int l = 0; l < 16; l++) begin
          e_sre[w][l] = 0; e_sim[w][l] = 0; e_dre[w][l] = 0; e_dim[w][l] = 0;
        end
      end
      return;
    end
    e_vld[1-u] = 0; e_done[1-u] = 0;
    e_vld[u] = 0; e_done[u] = 0;
    if (in_clr) begin
      mpos[u] = 0;
    end else if (in_v) begin
      if (mpos[u] < nd) begin
        for (int l = 0; l < nl; l++) begin
          mb_re[u][mpos[u]][l] = in_re[l];
          mb_im[u][mpos[u]][l] = in_im[l];
        end
      end else begin
        k = mpos[u] - nd;
        for (int l = 0; l < nl; l++) begin
          s_re = mb_re[u][k][l] + in_re[l];
          s_im = mb_im[u][k][l] + in_im[l];
          d_re = mb_re[u][k][l] - in_re[l];
          d_im = mb_im[u][k][l] - in_im[l];
          e_sre[u][l] = in_sc ? fl2(s_re) : s_re;
          e_sim[u][l] = in_sc ? fl2(s_im) : s_im;
          e_dre[u][l] = in_sc ? fl2(d_re) : d_re;
          e_dim[u][l] = in_sc ? fl2(d_im) : d_im;
        end
        e_vld[u] = 1; e_idx[u] = k; e_done[u] = (k == nd - 1);
      end
      mpos[u] = (mpos[u] + 1) % (2 * nd);
    end
  endtask

  task automatic step(int u);
    int a_sre, a_sim, a_dre, a_dim;
    v0 = (u == 0) && in_v; sc0 = (u == 0) && in_sc; clr0 = (u == 0) && in_clr;
    v1 = (u == 1) && in_v; sc1 = (u == 1) && in_sc; clr1 = (u == 1) && in_clr;
    if (u == 0) begin
      for (int l = 0; l < L0; l++) begin
        re0[l*I0 +: I0] = in_re[l][I0-1:0];
        im0[l*I0 +: I0] = in_im[l][I0-1:0];
      end
    end else begin
      for (int l = 0; l < L1; l++) begin
        re1[l*I1 +: I1] = in_re[l][I1-1:0];
        im1[l*I1 +: I1] = in_im[l][I1-1:0];
      end
    end
    model_step(u);
    @(posedge clk);
    #1;
    if (u == 0) begin
      check("dut0.valid", int'(ov0), int'(e_vld[0]));
      check("dut0.blk_done", int'(done0), int'(e_done[0]));
      check("dut0.idx", int'(idx0), e_idx[0]);
      check("dut1.idle_valid", int'(ov1), int'(e_vld[1]));
      for (int l = 0; l < L0; l++) begin
        a_sre = $signed(sre0[l*O0 +: O0]); a_sim = $signed(sim0[l*O0 +: O0]);
        a_dre = $signed(dre0[l*O0 +: O0]); a_dim = $signed(dim0[l*O0 +: O0]);
        check($sformatf("dut0.sum_re[%0d]", l), a_sre, e_sre[0][l]);
        check($sformatf("dut0.sum_im[%0d]", l), a_sim, e_sim[0][l]);
        check($sformatf("dut0.dif_re[%0d]", l), a_dre, e_dre[0][l]);
        check($sformatf("dut0.dif_im[%0d]", l), a_dim, e_dim[0][l]);
      end
    end else begin
      check("dut1.valid", int'(ov1), int'(e_vld[1]));
      check("dut1.blk_done", int'(done1), int'(e_done[1]));
      check("dut1.idx", int'(idx1), e_idx[1]);
      check("dut0.idle_valid", int'(ov0), int'(e_vld[0]));
      for (int l = 0; l < L1; l++) begin
        a_sre = $signed(sre1[l*O1 +: O1]); a_sim = $signed(sim1[l*O1 +: O1]);
        a_dre = $signed(dre1[l*O1 +: O1]); a_dim = $signed(dim1[l*O1 +: O1]);
        check($sformatf("dut1.sum_re[%0d]", l), a_sre, e_sre[1][l]);
        check($sformatf("dut1.sum_im[%0d]", l), a_sim, e_sim[1][l]);
        check($sformatf("dut1.dif_re[%0d]", l), a_dre, e_dre[1][l]);
        check($sformatf("dut1.dif_im[%0d]", l), a_dim, e_dim[1][l]);
      end
    end
  endtask

  task automatic set_const(int r, int i);
    for (int l = 0; l < 16; l++) begin
      in_re[l] = r; in_im[l] = i;
    end
  endtask

  task automatic set_rand(int u);
    int w;
    w = (u == 0) ? I0 : I1;
    for (int l = 0; l < 16; l++) begin
      in_re[l] = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
      in_im[l] = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    end
  endtask

  initial begin
    rstn = 1'b0; in_v = 0; in_sc = 0; in_clr = 0;
    v0 = 0; sc0 = 0; clr0 = 0; re0 = '0; im0 = '0;
    v1 = 0; sc1 = 0; clr1 = 0; re1 = '0; im1 = '0;
    set_const(0, 0);
    step(0); step(1);
    rstn = 1'b1;

    // Basic block
    in_v = 1;
    for (int k = 0; k < 8; k++) begin set_const(k, -k); step(0); end
    for (int k = 0; k < 8; k++) begin set_const(100, 0); step(0); end

    // Extremes
    for (int k = 0; k < 8; k++) begin set_const(-512, 511); step(0); end
    for (int k = 0; k < 8; k++) begin set_const(-512, -512); step(0); end

    // Scaling, toggled between beats
    for (int k = 0; k < 8; k++) begin set_const(k < 4 ? 3 : -3, k < 4 ? 3 : -3); step(0); end
    for (int k = 0; k < 8; k++) begin
      in_sc = (k < 4) ? 1 : k[0];
      set_const(k < 4 ? 4 : -4, k < 4 ? 4 : -4);
      step(0);
    end
    in_sc = 0;

    // Gapped basic block
    for (int k = 0; k < 16; k++) begin
      in_v = 1;
      if (k < 8) set_const(k, -k); else set_const(100, 0);
      step(0);
      in_v = 0; set_rand(0); step(0);
    end

    // Back-to-back blocks
    in_v = 1;
    for (int k = 0; k < 32; k++) begin
      set_rand(0); in_sc = $urandom_range(0, 1); step(0);
    end
    in_sc = 0;

    // Partial block, then sync_clr colliding with a beat, then a full block
    for (int k = 0; k < 5; k++) begin set_rand(0); step(0); end
    in_clr = 1; set_rand(0); step(0); in_clr = 0;
    for (int k = 0; k < 16; k++) begin set_rand(0); step(0); end

    // Reset after idx 3, then a fresh block
    for (int k = 0; k < 12; k++) begin set_rand(0); step(0); end
    rstn = 1'b0; set_rand(0); step(0); rstn = 1'b1;
    for (int k = 0; k < 16; k++) begin set_rand(0); step(0); end

    // Random soak
    for (int n = 0; n < 300; n++) begin
      in_v = ($urandom_range(0, 9) < 7);
      in_sc = $urandom_range(0, 1);
      in_clr = ($urandom_range(0, 29) == 0);
      set_rand(0); step(0);
    end
    in_v = 1; in_sc = 0; in_clr = 0;

    // Single-entry configuration
    set_const(0, 0); step(1);
    set_const(100, 0); step(1);
    for (int n = 0; n < 200; n++) begin
      in_v = ($urandom_range(0, 9) < 7);
      in_sc = $urandom_range(0, 1);
      in_clr = ($urandom_range(0, 29) == 0);
      set_rand(1); step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
